// File: rtl/lamp_pkg.sv
// Shared types and default timing for the lamp actuator/indicator controller.
// Timing constants are cycles of the 50 MHz board clock.
package lamp_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_DIM   = 2'b11
    } led_mode_t;

    localparam int POS_W   = 8;
    localparam int DUTY_W  = 8;
    localparam int PULSE_W = 20;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_SERVO_PERIOD = 1_000_000;
    localparam int DEF_PULSE_MIN    = 50_000;
    localparam int DEF_PULSE_STEP   = 196;
    localparam int DEF_SLEW_STEP    = 4;
    localparam int DEF_BLINK_HALF   = 12_500_000;
    localparam int DEF_FADE_DIV     = 65_536;

endpackage

// File: rtl/servo_channel.sv
// One servo channel: slew-limited position, frame-latched pulse width and enable.
// Latency: pwm/busy registered, 1 cycle; no backpressure, updates only at frame start.
// Target and enable changes mid-frame wait for the next frame start.
module servo_channel
    import lamp_pkg::*;
#(
    parameter int FC_W       = 20,
    parameter int PULSE_MIN  = DEF_PULSE_MIN,
    parameter int PULSE_STEP = DEF_PULSE_STEP,
    parameter int SLEW_STEP  = DEF_SLEW_STEP
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [FC_W-1:0]   frame_cnt,
    input  logic              enable,
    input  logic [POS_W-1:0]  target,
    output logic              pwm,
    output logic              busy
);

    localparam logic [PULSE_W-1:0] PMIN20   = PULSE_W'(PULSE_MIN);
    localparam logic [PULSE_W-1:0] STEP20   = PULSE_W'(PULSE_STEP);
    localparam logic [8:0]         STEP_LIM = 9'((SLEW_STEP > 255) ? 255 : SLEW_STEP);

    logic [POS_W-1:0]   cur_pos, cur_nxt;
    logic [PULSE_W-1:0] pulse_len, pulse_nxt;
    logic               en_q, en_nxt, pwm_nxt;
    logic [8:0]         diff;

    // At frame start the pulse is judged against the values being latched,
    // so the whole frame uses one consistent enable and width.
    always_comb begin
        cur_nxt   = cur_pos;
        pulse_nxt = pulse_len;
        en_nxt    = en_q;
        diff      = '0;
        if (frame_start) begin
            if (target > cur_pos) begin
                diff    = {1'b0, target} - {1'b0, cur_pos};
                cur_nxt = (diff > STEP_LIM) ? cur_pos + STEP_LIM[7:0] : target;
            end else if (target < cur_pos) begin
                diff    = {1'b0, cur_pos} - {1'b0, target};
                cur_nxt = (diff > STEP_LIM) ? cur_pos - STEP_LIM[7:0] : target;
            end
            pulse_nxt = PMIN20 + {12'd0, cur_nxt} * STEP20;
            en_nxt    = enable;
        end
        pwm_nxt = en_nxt && (32'(frame_cnt) < 32'(pulse_nxt));
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            cur_pos   <= '0;
            pulse_len <= PMIN20;
            en_q      <= 1'b0;
            pwm       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cur_pos   <= cur_nxt;
            pulse_len <= pulse_nxt;
            en_q      <= en_nxt;
            pwm       <= pwm_nxt;
            busy      <= (cur_pos != target);
        end
    end

endmodule

// File: rtl/lamp_ctrl.sv
// Lamp servo PWM and LED mode controller; optional duty fading with LAMP_FADE_EN.
// Latency: all outputs registered, 1 cycle from counter/mode state.
// No backpressure: free-running counters, inputs sampled every cycle.
module lamp_ctrl
    import lamp_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int N_SERVO      = 3,
    parameter int N_LED        = 4,
    parameter int SERVO_PERIOD = DEF_SERVO_PERIOD,
    parameter int PULSE_MIN    = DEF_PULSE_MIN,
    parameter int PULSE_STEP   = DEF_PULSE_STEP,
    parameter int SLEW_STEP    = DEF_SLEW_STEP,
    parameter int BLINK_HALF   = DEF_BLINK_HALF,
    parameter int FADE_DIV     = DEF_FADE_DIV
) (
    input  logic                      clk_50MHz,
    input  logic                      rst,
    input  logic [N_SERVO-1:0]        servo_en,
    input  logic [POS_W*N_SERVO-1:0]  servo_pos,
    input  logic [2*N_LED-1:0]        led_mode,
    input  logic [DUTY_W*N_LED-1:0]   led_duty,
    output logic [N_SERVO-1:0]        pwm_servo,
    output logic [N_SERVO-1:0]        servo_busy,
    output logic [N_LED-1:0]          led
);

    localparam int FC_W = (SERVO_PERIOD > 1) ? $clog2(SERVO_PERIOD) : 1;
    localparam int BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(SERVO_PERIOD - 1);
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_HALF - 1);

    if (CLK_HZ < 1 || N_SERVO < 1 || N_SERVO > 8 || N_LED < 1 || N_LED > 16 ||
        SERVO_PERIOD < 2 || FADE_DIV < 2) begin : g_param_err
        $error("lamp_ctrl: parameter out of range");
    end

    logic [FC_W-1:0]         frame_cnt;
    logic                    frame_start;
    logic [BC_W-1:0]         blink_cnt;
    logic                    blink_ph;
    logic [7:0]              dim_cnt;
    logic [DUTY_W*N_LED-1:0] eff_duty;
    logic [N_LED-1:0]        led_nxt;

    assign frame_start = (frame_cnt == '0);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            dim_cnt   <= '0;
        end else begin
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            // 255-cycle period so duty 255 means always on
            dim_cnt <= (dim_cnt == 8'd254) ? '0 : dim_cnt + 8'd1;
        end
    end

    for (genvar i = 0; i < N_SERVO; i++) begin : g_servo
        servo_channel #(
            .FC_W       (FC_W),
            .PULSE_MIN  (PULSE_MIN),
            .PULSE_STEP (PULSE_STEP),
            .SLEW_STEP  (SLEW_STEP)
        ) u_ch (
            .clk_50MHz   (clk_50MHz),
            .rst         (rst),
            .frame_start (frame_start),
            .frame_cnt   (frame_cnt),
            .enable      (servo_en[i]),
            .target      (servo_pos[POS_W*i +: POS_W]),
            .pwm         (pwm_servo[i]),
            .busy        (servo_busy[i])
        );
    end

`ifdef LAMP_FADE_EN
    localparam int FD_W = $clog2(FADE_DIV);
    localparam logic [FD_W-1:0] FADE_LAST = FD_W'(FADE_DIV - 1);

    logic [FD_W-1:0] fade_cnt;

    // eff_duty only moves while its LED is dimming; other modes freeze it
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            fade_cnt <= '0;
            eff_duty <= '0;
        end else begin
            fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + 1'b1;
            for (int j = 0; j < N_LED; j++) begin
                if (fade_cnt == FADE_LAST && led_mode[2*j +: 2] == LED_DIM) begin
                    if (eff_duty[DUTY_W*j +: DUTY_W] < led_duty[DUTY_W*j +: DUTY_W])
                        eff_duty[DUTY_W*j +: DUTY_W] <= eff_duty[DUTY_W*j +: DUTY_W] + 8'd1;
                    else if (eff_duty[DUTY_W*j +: DUTY_W] > led_duty[DUTY_W*j +: DUTY_W])
                        eff_duty[DUTY_W*j +: DUTY_W] <= eff_duty[DUTY_W*j +: DUTY_W] - 8'd1;
                end
            end
        end
    end
`else
    assign eff_duty = led_duty;
`endif

    always_comb begin
        led_nxt = '0;
        for (int j = 0; j < N_LED; j++) begin
            case (led_mode_t'(led_mode[2*j +: 2]))
                LED_OFF:   led_nxt[j] = 1'b0;
                LED_ON:    led_nxt[j] = 1'b1;
                LED_BLINK: led_nxt[j] = blink_ph;
                LED_DIM:   led_nxt[j] = (dim_cnt < eff_duty[DUTY_W*j +: DUTY_W]);
                default:   led_nxt[j] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) led <= '0;
        else     led <= led_nxt;
    end

endmodule

// File: tb/tb_lamp_ctrl.sv
// Randomized bench for lamp_ctrl against a cycle-count based reference model.
module tb_lamp_ctrl;
    import lamp_pkg::*;

    localparam int NS = 3, NL = 4;
    localparam int P = 400, PMIN = 50, PSTEP = 1, SLEW = 4, BH = 20, FD = 16;
    localparam int SPW = 8 * NS, DW = 8 * NL;

    logic            clk_50MHz = 1'b0;
    logic            rst = 1'b1;
    logic [NS-1:0]   servo_en = '0;
    logic [SPW-1:0]  servo_pos = '0;
    logic [2*NL-1:0] led_mode = '0;
    logic [DW-1:0]   led_duty = '0;
    logic [NS-1:0]   pwm_servo, servo_busy;
    logic [NL-1:0]   led;

    lamp_ctrl #(
        .CLK_HZ(50_000_000), .N_SERVO(NS), .N_LED(NL), .SERVO_PERIOD(P),
        .PULSE_MIN(PMIN), .PULSE_STEP(PSTEP), .SLEW_STEP(SLEW),
        .BLINK_HALF(BH), .FADE_DIV(FD)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .servo_en  (servo_en),
        .servo_pos (servo_pos),
        .led_mode  (led_mode),
        .led_duty  (led_duty),
        .pwm_servo (pwm_servo),
        .servo_busy(servo_busy),
        .led       (led)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_n counts clock edges since reset release, so every
    // counter value follows from m_n with modulo arithmetic.
    int m_n;
    int m_cur[NS];
    bit m_en[NS];
    int m_pulse[NS];
    int m_eff[NL];
    int fpos, d, tgt, md, du;
    logic [NS-1:0] e_pwm, e_busy;
    logic [NL-1:0] e_led;
    bit chk_on = 1'b0;

    always @(posedge clk_50MHz) begin
        if (rst) begin
            m_n = 0;
            for (int i = 0; i < NS; i++) begin
                m_cur[i] = 0; m_en[i] = 1'b0; m_pulse[i] = PMIN;
            end
            for (int j = 0; j < NL; j++) m_eff[j] = 0;
            e_pwm = '0; e_busy = '0; e_led = '0;
        end else begin
            fpos = m_n % P;
            for (int i = 0; i < NS; i++) begin
                tgt = int'(servo_pos[8*i +: 8]);
                e_busy[i] = (m_cur[i] != tgt);
                if (fpos == 0) begin
                    d = tgt - m_cur[i];
                    if (d > SLEW) d = SLEW;
                    if (d < -SLEW) d = -SLEW;
                    m_cur[i] += d;
                    m_en[i] = servo_en[i];
                    m_pulse[i] = PMIN + m_cur[i] * PSTEP;
                end
                e_pwm[i] = m_en[i] && (fpos < m_pulse[i]);
            end
            for (int j = 0; j < NL; j++) begin
                md = int'(led_mode[2*j +: 2]);
`ifdef LAMP_FADE_EN
                du = m_eff[j];
`else
                du = int'(led_duty[8*j +: 8]);
`endif
                case (md)
                    0: e_led[j] = 1'b0;
                    1: e_led[j] = 1'b1;
                    2: e_led[j] = ((m_n / BH) % 2) == 1;
                    default: e_led[j] = (m_n % 255) < du;
                endcase
`ifdef LAMP_FADE_EN
                if (m_n % FD == FD - 1 && md == 3) begin
                    if (m_eff[j] < int'(led_duty[8*j +: 8])) m_eff[j]++;
                    else if (m_eff[j] > int'(led_duty[8*j +: 8])) m_eff[j]--;
                end
`endif
            end
            m_n++;
        end
    end

    always @(negedge clk_50MHz) begin
        if (chk_on) begin
            chk("pwm_servo", 32'(pwm_servo), 32'(e_pwm));
            chk("servo_busy", 32'(servo_busy), 32'(e_busy));
            chk("led", 32'(led), 32'(e_led));
        end
    end

    task automatic count_hi(input int sel, input int idx, input int ncyc, output int cnt);
        cnt = 0;
        repeat (ncyc) begin
            @(negedge clk_50MHz);
            cnt += (sel == 0) ? int'(pwm_servo[idx]) : int'(led[idx]);
        end
    endtask

    int cnt;
    int dims[3] = '{0, 128, 255};

    initial begin
        @(negedge clk_50MHz);
        chk_on = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        chk("rst_pwm", 32'(pwm_servo), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(servo_busy), 32'd0);

        rst = 1'b0;
        servo_en = 3'b001;
        led_mode = {LED_DIM, LED_BLINK, LED_ON, LED_OFF};
        led_duty = {8'd128, 8'd0, 8'd0, 8'd0};
        repeat (2 * P) @(negedge clk_50MHz);
        count_hi(0, 0, P, cnt);
        chk("pw_min", 32'(cnt), 32'(PMIN));
        count_hi(1, 2, 2 * BH, cnt);
        chk("blink_half", 32'(cnt), 32'(BH));

        servo_pos = {8'($urandom), 8'($urandom), 8'd255};
        servo_en = {2'($urandom), 1'b1};
        repeat (64 * P) @(negedge clk_50MHz);
        chk("busy0_done", 32'(servo_busy[0]), 32'd0);
        count_hi(0, 0, P, cnt);
        chk("pw_max", 32'(cnt), 32'(PMIN + 255 * PSTEP));

        for (int k = 0; k < P; k++) begin
            if (m_n % P == P / 4) break;
            @(negedge clk_50MHz);
        end
        chk("dis_pulse_on", 32'(pwm_servo[0]), 32'd1);
        servo_en[0] = 1'b0;
        repeat (P) @(negedge clk_50MHz);
        count_hi(0, 0, P, cnt);
        chk("dis_no_pulse", 32'(cnt), 32'd0);

`ifndef LAMP_FADE_EN
        for (int k = 0; k < 3; k++) begin
            led_mode[7:6] = LED_DIM;
            led_duty[31:24] = 8'(dims[k]);
            count_hi(1, 3, 255, cnt);
            chk("dim_cnt", 32'(cnt), 32'(dims[k]));
        end
`endif

        for (int it = 0; it < 40; it++) begin
            servo_en = NS'($urandom);
            servo_pos = SPW'($urandom);
            led_mode = (2 * NL)'($urandom);
            for (int j = 0; j < NL; j++) begin
                case ($urandom_range(0, 2))
                    0: led_duty[8*j +: 8] = 8'd0;
                    1: led_duty[8*j +: 8] = 8'd255;
                    default: led_duty[8*j +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            if (it % 13 == 7) begin
                rst = 1'b1;
                @(negedge clk_50MHz);
                chk("mid_rst_pwm", 32'(pwm_servo), 32'd0);
                chk("mid_rst_led", 32'(led), 32'd0);
                @(negedge clk_50MHz);
                rst = 1'b0;
            end
            repeat ($urandom_range(20, 600)) @(negedge clk_50MHz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
